// File: rtl/register_unit.sv
// Architectural integer register file (x0..x31) for the RV32I single-cycle core.
// After reset a sequencer zeroes x1..x(NREGS-1), one per cycle, before the file
// reports ready. It has two combinational read ports, a debug read port and a
// saturating count of accepted writes.
module register_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned ADDR_W = 5,   // must equal log2(NREGS)
  parameter int unsigned WCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic [XLEN-1:0]   wr_data,
  input  logic              wr_en,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [XLEN-1:0]   dbg_data,
  output logic              ready,
  output logic [WCNT_W-1:0] write_count
);

  localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(NREGS - 1);
  localparam logic [ADDR_W-1:0] FirstIdx = ADDR_W'(1);

  typedef enum logic [0:0] {
    StClear,
    StRun
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic [WCNT_W-1:0] count_q, count_d;

  logic clr_active;  // a clearing write happens at the coming edge
  logic clr_last;    // the coming edge clears the highest register
  logic wr_accept;   // the coming edge commits the port write

  // Register file as seen by the read muxes; x0 is a constant zero row.
  logic [NREGS-1:0][XLEN-1:0] rf;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------

  // Qualify clearing and write acceptance; reset overrides both.
  always_comb begin
    clr_active = (state_q == StClear) && !rst;
    clr_last   = clr_active && (clr_idx_q == LastIdx);
    wr_accept  = (state_q == StRun) && wr_en && !rst && (rd != '0);
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------

  // State register; reset always restarts the clearing pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StClear;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave CLEAR on the edge that zeroes the last register.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StClear: if (clr_last) state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StClear;
    endcase
  end

  // Outputs of the FSM.
  always_comb begin
    ready = (state_q == StRun);
  end

  // ---------------------------------------------------------------------------
  // Clear index
  // ---------------------------------------------------------------------------

  // Advance the clear pointer once per clearing edge; x0 is never stored.
  always_comb begin
    clr_idx_d = clr_idx_q;
    if (clr_active) begin
      clr_idx_d = clr_idx_q + FirstIdx;
    end
  end

  // Clear pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_idx_q <= FirstIdx;
    end else begin
      clr_idx_q <= clr_idx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Accepted-write counter
  // ---------------------------------------------------------------------------

  // Count accepted writes, sticking at all-ones.
  always_comb begin
    count_d = count_q;
    if (wr_accept && (count_q != '1)) begin
      count_d = count_q + WCNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign write_count = count_q;

  // ---------------------------------------------------------------------------
  // Storage: one enable-gated flop bank per architectural register x1..xN-1
  // ---------------------------------------------------------------------------

  assign rf[0] = '0;

  for (genvar i = 1; i < NREGS; i++) begin : g_reg
    logic            en;
    logic [XLEN-1:0] d;
    logic [XLEN-1:0] q;

    // Load enable and data: clearing and port writes never overlap in time.
    always_comb begin
      en = (clr_active && (clr_idx_q == ADDR_W'(i))) ||
           (wr_accept && (rd == ADDR_W'(i)));
      d  = clr_active ? '0 : wr_data;
    end

    // Contents are deliberately not reset; the sequencer zeroes them.
    always_ff @(posedge clk) begin
      if (en) begin
        q <= d;
      end
    end

    assign rf[i] = q;
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------

  // Combinational reads of current contents; no bypass of the pending write.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    dbg_data = '0;
    if (ready) begin
      rs1_data = rf[rs1];
      rs2_data = rf[rs2];
      dbg_data = rf[dbg_addr];
    end
  end

endmodule

// File: tb/tb_register_unit.sv
// Self-checking bench for register_unit: a behavioural model tracks contents,
// time since reset and the number of accepted writes; a compare process checks
// every output each cycle. Directed sequences pin the model with literal values.
module tb_register_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0, dbg_addr = '0;
  logic [31:0] wr_data = '0;

  logic [31:0] rs1_data, rs2_data, dbg_data;
  logic        ready;
  logic [15:0] write_count;

  logic [31:0] s_rs1_data, s_rs2_data, s_dbg_data;
  logic        s_ready;
  logic [3:0]  s_write_count;

  int errors = 0;
  int checks = 0;

  // Behavioural model
  logic [31:0] m_regs [32];
  int          m_since = 0;   // non-reset edges since the last reset edge
  int          m_cnt   = 0;   // accepted writes, unsaturated
  bit          m_valid = 1'b0;

  register_unit dut (
    .clk        (clk),
    .rst        (rst),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .ready      (ready),
    .write_count(write_count)
  );

  register_unit #(.WCNT_W(4)) dut_s (
    .clk        (clk),
    .rst        (rst),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .rs1_data   (s_rs1_data),
    .rs2_data   (s_rs2_data),
    .dbg_addr   (dbg_addr),
    .dbg_data   (s_dbg_data),
    .ready      (s_ready),
    .write_count(s_write_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    return (m_since >= 31 && a != 5'd0) ? m_regs[a] : 32'h0;
  endfunction

  function automatic logic [31:0] sat(input int v, input int maxv);
    return 32'((v > maxv) ? maxv : v);
  endfunction

  // Model: 31 clearing edges after reset, then all of x1..x31 are zero and
  // writes to non-zero addresses are taken.
  always @(posedge clk) begin
    if (rst) begin
      m_since = 0;
      m_cnt   = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_since >= 31) begin
        if (wr_en && rd != 5'd0) begin
          m_regs[rd] = wr_data;
          m_cnt++;
        end
      end else begin
        m_since++;
        if (m_since == 31) begin
          for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        end
      end
    end
  end

  // Compare every output against the model, away from the active edge.
  always @(negedge clk) begin
    #2;
    if (m_valid) begin
      chk("ready",     {31'b0, ready},         32'(m_since >= 31));
      chk("s_ready",   {31'b0, s_ready},       32'(m_since >= 31));
      chk("wcount",    {16'b0, write_count},   sat(m_cnt, 65535));
      chk("s_wcount",  {28'b0, s_write_count}, sat(m_cnt, 15));
      chk("rs1_data",  rs1_data,               m_read(rs1));
      chk("rs2_data",  rs2_data,               m_read(rs2));
      chk("dbg_data",  dbg_data,               m_read(dbg_addr));
      chk("s_dbg",     s_dbg_data,             m_read(dbg_addr));
    end
  end

  // Leaves the bench at the negedge just after the reset edge, rst low.
  task automatic pulse_rst();
    @(negedge clk);
    rst   = 1'b1;
    wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Counts sampled cycles with ready low; returns at negedge+2 with ready high.
  task automatic wait_ready(input string name);
    int n = 0;
    while (n < 100) begin
      #2;
      if (ready === 1'b1) break;
      n++;
      @(negedge clk);
    end
    chk(name, 32'(n), 32'd31);
  endtask

  task automatic sweep_zero(input string name);
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      dbg_addr = a[4:0];
      rs1      = a[4:0];
      rs2      = 5'(31 - a);
      #2;
      chk(name, dbg_data, 32'h0);
    end
  endtask

  task automatic write1(input logic [4:0] r, input logic [31:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    rd      = r;
    wr_data = d;
  endtask

  initial begin
    // Reset and clear, with a write to x3 presented throughout CLEAR.
    pulse_rst();
    wr_en   = 1'b1;
    rd      = 5'd3;
    wr_data = 32'h1234_5678;
    rs1     = 5'd3;
    rs2     = 5'd9;
    wait_ready("clear_len");
    wr_en = 1'b0;
    sweep_zero("dbg_after_clear");
    @(negedge clk);
    rs1 = 5'd3;
    #2;
    chk("x3_clear_write_dropped", rs1_data, 32'h0);
    chk("count_after_clear", {16'b0, write_count}, 32'd0);

    // Basic write/read.
    write1(5'd5, 32'hDEAD_BEEF);
    rs1 = 5'd5;
    rs2 = 5'd0;
    @(negedge clk);
    wr_en = 1'b0;
    #2;
    chk("basic_rs1", rs1_data, 32'hDEAD_BEEF);
    chk("basic_rs2", rs2_data, 32'h0);
    chk("basic_count", {16'b0, write_count}, 32'd1);

    // Write to x0 is dropped and not counted.
    write1(5'd0, 32'hFFFF_FFFF);
    @(negedge clk);
    wr_en = 1'b0;
    rs1   = 5'd0;
    #2;
    chk("x0_read", rs1_data, 32'h0);
    chk("x0_count", {16'b0, write_count}, 32'd1);

    // Same-cycle hazard: old value this cycle, new value next.
    write1(5'd7, 32'h1);
    write1(5'd7, 32'h2);
    rs1 = 5'd7;
    rs2 = 5'd7;
    #2;
    chk("hazard_rs1_old", rs1_data, 32'h1);
    chk("hazard_rs2_old", rs2_data, 32'h1);
    @(negedge clk);
    wr_en = 1'b0;
    #2;
    chk("hazard_rs1_new", rs1_data, 32'h2);
    chk("hazard_rs2_new", rs2_data, 32'h2);

    // Reset mid-clear after filling every register.
    for (int a = 1; a < 32; a++) write1(5'(a), $urandom | 32'h1);
    pulse_rst();
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_ready("clear_len_restart");
    sweep_zero("dbg_after_restart");

    // Counter saturation on the 4-bit instance.
    for (int i = 1; i <= 20; i++) begin
      write1(5'((i % 31) + 1), 32'(i));
      @(negedge clk);
      wr_en = 1'b0;
      #2;
      chk("sat_count", {28'b0, s_write_count}, 32'((i < 15) ? i : 15));
      if (i == 15) chk("sat_at_15", {28'b0, s_write_count}, 32'd15);
    end
    chk("wide_count_20", {16'b0, write_count}, 32'd20);
    pulse_rst();
    #2;
    chk("sat_reset", {28'b0, s_write_count}, 32'd0);

    // Randomized traffic with occasional resets, including reset during writes.
    repeat (3000) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 199) == 0);
      wr_en    = $urandom_range(0, 1) == 1;
      rd       = 5'($urandom_range(0, 31));
      wr_data  = $urandom;
      rs1      = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rs2      = 5'($urandom_range(0, 31));
      dbg_addr = 5'($urandom_range(0, 31));
    end
    @(negedge clk);
    rst   = 1'b0;
    wr_en = 1'b0;
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/register_unit.md
# register_unit

Architectural integer register file (x0–x31) for the RV32I single-cycle core. It is built from banks of the team's enable-gated flip-flop cells and sits between the decode stage (rs1/rs2/rd fields) and the ALU/write-back path. It adds a post-reset clearing sequencer, a `ready` status output, a debug read port and a saturating accepted-write counter.

## Interface
Parameters:
- `XLEN`, default 32: data width of each register.
- `NREGS`, default 32: number of architectural registers; x0 is hardwired to zero.
- `ADDR_W`, default 5: register address width; must equal log2(`NREGS`).
- `WCNT_W`, default 16: width of the write counter.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `rs1`, input, `ADDR_W`: read address A.
- `rs2`, input, `ADDR_W`: read address B.
- `rd`, input, `ADDR_W`: write address.
- `wr_data`, input, `XLEN`: write data.
- `wr_en`, input, 1: write request.
- `rs1_data`, output, `XLEN`: combinational read of `rs1`.
- `rs2_data`, output, `XLEN`: combinational read of `rs2`.
- `dbg_addr`, input, `ADDR_W`: debug read address.
- `dbg_data`, output, `XLEN`: combinational read of `dbg_addr`.
- `ready`, output, 1: clearing complete; the register file is usable.
- `write_count`, output, `WCNT_W`: number of accepted writes, saturating.

## Operation
**Two states:**
- CLEAR: `ready`=0.
- RUN: `ready`=1.

**Reset and CLEAR:**
- `rst` sampled high forces state to CLEAR, `clr_idx`=1 and `write_count`=0.
- Register contents are not touched during the `rst` cycle itself.
- In CLEAR with `rst` low, each edge writes 0 to register `clr_idx`, then increments `clr_idx`.
- When the edge that clears index `NREGS`-1 occurs, the state goes to RUN.

**Writes:**
- A write is accepted when state=RUN, `wr_en`=1, `rst`=0 and `rd`≠0.
- On acceptance, the register `rd` takes `wr_data` at the edge.
- `wr_en` with `rd`=0 is silently dropped and not counted.
- Writes while in CLEAR are dropped and not counted. There is no buffering and no retry.

**Reads:**
- Reads are purely combinational from current contents. There is no write-to-read bypass, because the single-cycle datapath would otherwise form a combinational loop.
- Address 0 always returns 0.
- While `ready`=0, `rs1_data`, `rs2_data` and `dbg_data` are forced to 0 regardless of address.

**Counter:**
- `write_count` increments by 1 on each accepted write.
- It saturates at all-ones and holds there until `rst`.

## Timing
**Reset values, effective after the `rst` edge:**
- `ready`=0, `write_count`=0.
- `rs1_data`, `rs2_data` and `dbg_data` are all 0.

**Clearing latency:**
- With `rst` high at edge E and low afterwards, edges E+1 … E+31 clear x1 … x31.
- `ready` rises after edge E+31, i.e. 31 cycles (`NREGS`-1) after the reset edge.

**Write latency:**
- `wr_data` is visible on a read port in the same cycle that follows the accepting edge.
- The old value is read during the cycle in which the write is presented.

**Boundary conditions:**
- `rst` asserted mid-CLEAR: the sequencer restarts at `clr_idx`=1, and the full 31-cycle clear is repeated.
- `rst` asserted in RUN while `wr_en`=1: the write is dropped. Reset wins on simultaneous events.
- `rs1`=`rs2`=`rd` with `wr_en`=1 in RUN: both read ports return the old value in that cycle and the new value in the next cycle.
- `write_count` at all-ones with another accepted write: it stays at all-ones, with no wrap-around.
- `dbg_addr` has no side effects, and reading it never changes any state.

## Test plan
- **Reset and clear:** pulse `rst` for 1 cycle, then hold `wr_en`=0.
  - `ready`=0 for exactly 31 cycles, then 1.
  - All reads return 0 throughout.
  - After `ready`, `dbg_data`=0 for every address 0..31.
- **Basic write/read:** in RUN, write `rd`=5 with 0xDEADBEEF, then set `rs1`=5 and `rs2`=0.
  - `rs1_data`=0xDEADBEEF next cycle; `rs2_data`=0.
  - `write_count`=1.
- **x0 and CLEAR-phase writes:**
  - Write `rd`=0 with 0xFFFFFFFF in RUN, and write `rd`=3 with 0x12345678 during CLEAR.
  - After `ready`: x0 reads 0, x3 reads 0, `write_count`=0.
- **Same-cycle hazard:** hold x7=0x1 in RUN; present a write of 0x2 to `rd`=7 with `rs1`=`rs2`=7.
  - Both ports read 0x1 that cycle and 0x2 the next.
- **Reset mid-clear:** assert `rst` 10 cycles into CLEAR.
  - `ready` rises 31 cycles after the second reset edge, not 21.
  - With prior values in x1..x31, all read 0 afterwards.
- **Counter saturation:** with `WCNT_W`=4, perform 20 accepted writes.
  - `write_count` reads 15 after the 15th write and stays at 15.
  - `rst` returns it to 0.
